// File: rtl/eq_pkg.sv
// eq_pkg: shared widths, constants and FSM encoding for the equalizer band mixer.
//   BAND_W     : band filter output width (Q.15 taps)
//   GAIN_W     : per-band gain width, Q4.12
//   OUT_W      : output sample width
//   ACC_W      : accumulator width (48-bit product + 3 guard bits for 8 bands)
//   GAIN_UNITY : gain code for 1.0
package eq_pkg;

    localparam int NUM_BANDS  = 8;
    localparam int BAND_W     = 32;
    localparam int GAIN_W     = 16;
    localparam int OUT_W      = 16;
    localparam int ACC_W      = 51;
    localparam int GAIN_UNITY = 4096;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/eq_sat_round.sv
// eq_sat_round: combinational scale/saturate of the mixer accumulator.
//   acc   in  ACC_W : signed accumulated sum of band*gain products
//   value out OUT_W : (acc [+ half LSB]) >>> SHIFT, clamped to the OUT_W range
//   clip  out 1     : the shifted value was outside the OUT_W range
// Macro EQ_MIXER_ROUND_EN: round half up before the shift; otherwise floor.
module eq_sat_round
    import eq_pkg::*;
#(
    parameter int SHIFT = 27
)(
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [OUT_W-1:0] value,
    output logic                    clip
);

    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [ACC_W-1:0] pre;
    logic signed [ACC_W-1:0] shifted;

`ifdef EQ_MIXER_ROUND_EN
    // Half an output LSB; the accumulator has headroom so this cannot wrap.
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (SHIFT-1);
    assign pre = acc + HALF;
`else
    assign pre = acc;
`endif

    assign shifted = pre >>> SHIFT;

    always_comb begin
        clip  = 1'b0;
        value = shifted[OUT_W-1:0];
        if (shifted > MAX_V) begin
            value = MAX_V[OUT_W-1:0];
            clip  = 1'b1;
        end else if (shifted < MIN_V) begin
            value = MIN_V[OUT_W-1:0];
            clip  = 1'b1;
        end
    end

endmodule

// File: rtl/eq_band_mixer.sv
// eq_band_mixer: weighted recombination of the equalizer band filter outputs.
// Captures all bands and gains on sample_valid, accumulates band*gain one band
// per cycle through a single multiplier, then scales/saturates to 16 bits.
//   clk, rst     : clock, synchronous active-high reset
//   sample_valid : capture pulse for band_in/gain (accepted only when idle)
//   band_in      : NUM_BANDS x 32-bit signed band outputs, band i at [32i+31:32i]
//   gain         : NUM_BANDS x 16-bit signed Q4.12 gains, band i at [16i+15:16i]
//   clr_overrun  : clears overrun (a same-cycle new overrun takes priority)
//   data_out     : saturated output sample, held between updates
//   out_valid    : one-cycle pulse when data_out/clip update
//   clip         : result was saturated
//   busy         : sample in flight
//   overrun      : sticky, a sample_valid arrived while busy
// Macro EQ_MIXER_ROUND_EN (in eq_sat_round): round half up instead of floor.
module eq_band_mixer
    import eq_pkg::*;
#(
    parameter int NUM_BANDS = eq_pkg::NUM_BANDS,
    parameter int SHIFT     = 27
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sample_valid,
    input  logic [NUM_BANDS*BAND_W-1:0]   band_in,
    input  logic [NUM_BANDS*GAIN_W-1:0]   gain,
    input  logic                          clr_overrun,
    output logic signed [OUT_W-1:0]       data_out,
    output logic                          out_valid,
    output logic                          clip,
    output logic                          busy,
    output logic                          overrun
);

    localparam int IDX_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BANDS-1);

    state_t                               state;
    logic [NUM_BANDS-1:0][BAND_W-1:0]     band_reg;
    logic [NUM_BANDS-1:0][GAIN_W-1:0]     gain_reg;
    logic [IDX_W-1:0]                     idx;
    logic signed [ACC_W-1:0]              acc;

    logic signed [BAND_W+GAIN_W-1:0]      prod;
    logic signed [ACC_W-1:0]              prod_ext;
    logic signed [OUT_W-1:0]              sat_val;
    logic                                 sat_clip;

    // Single shared multiplier, stepped across the captured bands by idx.
    assign prod     = $signed(band_reg[idx]) * $signed(gain_reg[idx]);
    assign prod_ext = ACC_W'(prod);

    eq_sat_round #(.SHIFT(SHIFT)) u_sat (
        .acc   (acc),
        .value (sat_val),
        .clip  (sat_clip)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            band_reg  <= '0;
            gain_reg  <= '0;
            idx       <= '0;
            acc       <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            clip      <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= 1'b0;

            if (sample_valid && state != IDLE)
                overrun <= 1'b1;
            else if (clr_overrun)
                overrun <= 1'b0;

            case (state)
                IDLE: begin
                    if (sample_valid) begin
                        band_reg <= band_in;
                        gain_reg <= gain;
                        acc      <= '0;
                        idx      <= '0;
                        busy     <= 1'b1;
                        state    <= ACC;
                    end
                end
                ACC: begin
                    acc <= acc + prod_ext;
                    idx <= idx + IDX_W'(1);
                    if (idx == LAST_IDX)
                        state <= OUT;
                end
                OUT: begin
                    data_out  <= sat_val;
                    clip      <= sat_clip;
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/eq_band_mixer.md
# eq_band_mixer

Post-filter recombination stage of the 8-band equalizer: consumes the 32-bit outputs of the eight band FIR filters, applies a per-band signed gain, sums the weighted bands with a time-multiplexed single multiplier, then scales and saturates the result to a 16-bit output sample. It sits directly downstream of the eight band filters and drives the equalizer output. It produces one output sample per 15-cycle filter frame.

## Interface
Parameters:
- `NUM_BANDS`, 8: number of bands accumulated.
- `SHIFT`, 27: arithmetic right shift applied to the accumulator. This is the 15-bit filter tap fraction plus the 12-bit gain fraction.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `sample_valid` in 1: one-cycle pulse; band outputs are stable in this cycle.
- `band_in` in 256: packed signed band outputs; band i is at [32*i+31:32*i].
- `gain` in 128: packed signed gains, Q4.12 (unity = 4096); band i is at [16*i+15:16*i].
- `clr_overrun` in 1: clears `overrun`.
- `data_out` out 16: signed output sample; holds its value between updates.
- `out_valid` out 1: one-cycle pulse when `data_out` updates.
- `clip` out 1: valid with `out_valid`; 1 if the result was saturated.
- `busy` out 1: high while a sample is being processed.
- `overrun` out 1: sticky flag; set when a `sample_valid` pulse is dropped.

## Operation
- FSM states are IDLE, ACC and OUT. Reset state is IDLE.
- **IDLE:**
  - On `sample_valid`, register all of `band_in` and `gain`, clear the accumulator and the band index, and go to ACC.
  - Otherwise stay in IDLE.
- **ACC:**
  - Each cycle: acc <= acc + band_reg[idx] * gain_reg[idx].
  - The product is a 32x16 signed multiply giving 48 bits, sign-extended into a 51-bit accumulator. The accumulator cannot overflow.
  - idx counts 0 to NUM_BANDS-1. Leave ACC after idx = NUM_BANDS-1 and go to OUT.
- **OUT:**
  - Compute r = acc >>> SHIFT (arithmetic shift).
  - Saturate r to [-32768, 32767] and register it in `data_out`.
  - `clip` = 1 if r was out of range, else 0.
  - Pulse `out_valid`, then return to IDLE.
- **Dropped samples:** a `sample_valid` pulse in ACC or OUT is ignored and sets `overrun`.
- **Overrun priority:** if a set and `clr_overrun` occur in the same cycle, the set wins.
- **Input isolation:** `band_in` and `gain` are used only at capture. Changes after capture do not affect the sample in flight.

## Timing
- Reset values (all outputs): `data_out` = 0, `out_valid` = 0, `clip` = 0, `busy` = 0, `overrun` = 0. The FSM returns to IDLE, and the accumulator and index clear.
- **Latency:**
  - `sample_valid` is sampled high in IDLE in cycle T.
  - ACC occupies cycles T+1 to T+8. OUT is cycle T+9.
  - `data_out`, `clip` and `out_valid` are visible in cycle T+10.
- `busy` is high in cycles T+1 to T+9.
- A new sample is accepted from cycle T+10. The sample period is 10 cycles or more, which fits inside the 15-cycle frame.
- **Reset mid-operation:** the sample in flight is abandoned. No `out_valid` is produced, and `data_out` reads 0.
- `sample_valid` held high for several cycles counts as one accepted pulse plus overruns for each further cycle in ACC or OUT.

## Configuration
- **`EQ_MIXER_ROUND_EN` defined:** in OUT, add 2^(SHIFT-1) to acc before the shift (round half up). Saturation is applied after rounding.
- **Not defined:** plain arithmetic shift (floor truncation). No adder is generated.

## Structure
- **Package `eq_pkg`:**
  - NUM_BANDS
  - widths BAND_W = 32, GAIN_W = 16, OUT_W = 16, ACC_W = 51
  - GAIN_UNITY = 4096
  - the FSM state enum
- **Sub-module `eq_sat_round`:** combinational round (under the macro), shift and saturate, producing the value and the clip flag. It is instantiated once in OUT.
- The multiplier and accumulator stay in the top module.

## Test plan
- **Unity, single band:** band0 = 3276800 (100<<15), gain0 = 4096, other bands and gains 0, pulse `sample_valid` at T -> `data_out` = 100, `clip` = 0, `out_valid` only in T+10.
- **All bands:** every band = 32768, every gain = 4096 -> `data_out` = 8. With gain3 = -4096 instead -> `data_out` = 6.
- **Saturation:**
  - All bands = 0x7FFFFFFF, gains = 32767 -> `data_out` = 32767, `clip` = 1.
  - Negate all bands -> `data_out` = -32768, `clip` = 1.
- **Rounding:** band0 = -3, gain0 = 4096 -> `data_out` = -1 without `EQ_MIXER_ROUND_EN`, and 0 with it.
- **Overrun:**
  - Pulses at T and T+4 -> one output at T+10 and `overrun` = 1.
  - A pulse at T+10 is accepted.
  - `clr_overrun` clears the flag; clear and a new overrun in the same cycle leaves `overrun` = 1.
- **Reset mid-operation:** `rst` asserted at T+5 -> no `out_valid`, all outputs 0, and a pulse after reset is processed normally.
